// File: rtl/updn_sweep_ctrl.sv
// Sequencer for an external up/down counter: seeks a start limit, then sweeps
// between latched LO/HI limits once, forever (ping-pong), or for NPASS passes.
module updn_sweep_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic             STOP,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] LO,
    input  logic [WIDTH-1:0] HI,
    input  logic [3:0]       NPASS,
    input  logic [WIDTH-1:0] Q,
    output logic             CNT_EN,
    output logic             UD,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [3:0]       PASS
);

    typedef enum logic [1:0] {S_IDLE, S_SEEK, S_UP, S_DOWN} state_t;

    localparam logic [1:0] M_UP_ONCE = 2'b00;
    localparam logic [1:0] M_DN_ONCE = 2'b01;
    localparam logic [1:0] M_NPASS   = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [3:0]       npass_q, npass_d;
    logic [3:0]       pass_q, pass_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [3:0] pass_inc;
    logic       last_pass;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; combinational blocks below use blocking.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            tgt_q   <= '0;
            npass_q <= '0;
            pass_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            tgt_q   <= tgt_d;
            npass_q <= npass_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign pass_inc  = (pass_q == 4'hF) ? 4'hF : pass_q + 4'd1;
    assign last_pass = ({1'b0, pass_q} + 5'd1) == {1'b0, npass_q};

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        tgt_d   = tgt_q;
        npass_d = npass_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (LO >= HI || (MODE == M_NPASS && NPASS == 4'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = MODE;
                        lo_d    = LO;
                        hi_d    = HI;
                        npass_d = NPASS;
                        pass_d  = 4'd0;
                        tgt_d   = (MODE == M_DN_ONCE) ? HI : LO;
                        state_d = S_SEEK;
                    end
                end
            end
            S_SEEK: begin
                if (STOP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (Q == tgt_q) begin
                    state_d = (mode_q == M_DN_ONCE) ? S_DOWN : S_UP;
                end
            end
            S_UP: begin
                if (STOP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (Q == hi_q) begin
                    pass_d = pass_inc;
                    if (mode_q == M_UP_ONCE || (mode_q == M_NPASS && last_pass)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DOWN;
                    end
                end
            end
            S_DOWN: begin
                if (STOP) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (Q == lo_q) begin
                    pass_d = pass_inc;
                    if (mode_q == M_DN_ONCE || (mode_q == M_NPASS && last_pass)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_UP;
                    end
                end
            end
            default: ;
        endcase
    end

    // STOP gates the enable in the same cycle so the counter cannot step past an abort.
    always_comb begin
        CNT_EN = 1'b0;
        UD     = 1'b0;
        unique case (state_q)
            S_SEEK: begin
                CNT_EN = (Q != tgt_q) && !STOP;
                UD     = (Q < tgt_q);
            end
            S_UP: begin
                CNT_EN = (Q != hi_q) && !STOP;
                UD     = 1'b1;
            end
            S_DOWN: begin
                CNT_EN = (Q != lo_q) && !STOP;
                UD     = 1'b0;
            end
            default: ;
        endcase
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = done_q;
    assign ERR  = err_q;
    assign PASS = pass_q;

endmodule
